// File: rtl/partita_pkg.sv
// rtl/partita_pkg.sv - shared state and code definitions for the match scoreboard
package partita_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GIOCO = 2'b01,
    FINE  = 2'b10
  } state_e;

  localparam logic [1:0] M_INVALID = 2'b00;
  localparam logic [1:0] M_PRIMO   = 2'b01;
  localparam logic [1:0] M_SECONDO = 2'b10;
  localparam logic [1:0] M_PARI    = 2'b11;

  localparam logic [1:0] P_ONGOING = 2'b00;
  localparam logic [1:0] P_PRIMO   = 2'b01;
  localparam logic [1:0] P_SECONDO = 2'b10;
  localparam logic [1:0] P_PARI    = 2'b11;

endpackage

// File: rtl/partita_scoreboard_sat_counter.sv
// rtl/partita_scoreboard_sat_counter.sv - clearable up-counter that clamps at all-ones
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (inc && (q_q != '1)) begin
      q_q <= q_q + ONE;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/partita_scoreboard.sv
// rtl/partita_scoreboard.sv - round tallies, outcome history and match-end event
// Optional: SCOREBOARD_AUTOFINE_EN ends the match when a player's tally saturates.
module partita_scoreboard
  import partita_pkg::*;
#(
  parameter int CW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 INIZIO_SETUP,
  input  logic                 MANCHE_VALID,
  input  logic [1:0]           MANCHE,
  input  logic [1:0]           PARTITA,
  output logic [CW-1:0]        PUNTI_PRIMO,
  output logic [CW-1:0]        PUNTI_SECONDO,
  output logic [CW-1:0]        PAREGGI,
  output logic [CW-1:0]        ROUNDS,
  output logic [2*DEPTH-1:0]   HISTORY,
  output logic [1:0]           STATO,
  output logic                 EVT_VALID,
  output logic [1:0]           EVT_WINNER,
  input  logic                 EVT_READY
);

  state_e             state_q, state_d;
  logic [2*DEPTH-1:0] hist_q, hist_d;
  logic               evt_valid_q, evt_valid_d;
  logic [1:0]         evt_winner_q, evt_winner_d;

  logic take, inc_p, inc_s, inc_pari, inc_r;
  logic [1:0] auto_win;

  // A round is only sampled in GIOCO, and setup always wins over it
  assign take     = (state_q == GIOCO) && MANCHE_VALID && !INIZIO_SETUP;
  assign inc_p    = take && (MANCHE == M_PRIMO);
  assign inc_s    = take && (MANCHE == M_SECONDO);
  assign inc_pari = take && (MANCHE == M_PARI);
  assign inc_r    = take && (MANCHE != M_INVALID);

`ifdef SCOREBOARD_AUTOFINE_EN
  localparam logic [CW-1:0] SAT_M1 = {{(CW-1){1'b1}}, 1'b0};
  assign auto_win = {inc_s && (PUNTI_SECONDO == SAT_M1),
                     inc_p && (PUNTI_PRIMO == SAT_M1)};
`else
  assign auto_win = 2'b00;
`endif

  sat_counter #(.W(CW)) u_primo (
    .clk(clk), .rst_n(rst_n), .clr(INIZIO_SETUP), .inc(inc_p), .q(PUNTI_PRIMO)
  );
  sat_counter #(.W(CW)) u_secondo (
    .clk(clk), .rst_n(rst_n), .clr(INIZIO_SETUP), .inc(inc_s), .q(PUNTI_SECONDO)
  );
  sat_counter #(.W(CW)) u_pari (
    .clk(clk), .rst_n(rst_n), .clr(INIZIO_SETUP), .inc(inc_pari), .q(PAREGGI)
  );
  sat_counter #(.W(CW)) u_rounds (
    .clk(clk), .rst_n(rst_n), .clr(INIZIO_SETUP), .inc(inc_r), .q(ROUNDS)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hist_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_winner_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      evt_valid_q  <= evt_valid_d;
      evt_winner_q <= evt_winner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    evt_valid_d  = evt_valid_q;
    evt_winner_d = evt_winner_q;
    if (INIZIO_SETUP) begin
      state_d     = GIOCO;
      hist_d      = '0;
      evt_valid_d = 1'b0;
    end else begin
      if (evt_valid_q && EVT_READY) begin
        evt_valid_d = 1'b0;
      end
      if (inc_r) begin
        hist_d = {hist_q[2*DEPTH-3:0], MANCHE};
      end
      // An explicit match result takes precedence over a saturation finish
      if (take && (PARTITA != P_ONGOING)) begin
        state_d      = FINE;
        evt_valid_d  = 1'b1;
        evt_winner_d = PARTITA;
      end else if (take && (auto_win != 2'b00)) begin
        state_d      = FINE;
        evt_valid_d  = 1'b1;
        evt_winner_d = auto_win;
      end
    end
  end

  assign HISTORY    = hist_q;
  assign STATO      = state_q;
  assign EVT_VALID  = evt_valid_q;
  assign EVT_WINNER = evt_winner_q;

endmodule

// File: tb/tb_partita_scoreboard.sv
// tb/tb_partita_scoreboard.sv - directed scoreboard bench for partita_scoreboard
module tb_partita_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       setup, mv, rd;
  logic [1:0] m, p;
  logic [3:0] pp, ps, pa, rn;
  logic [7:0] hist;
  logic [1:0] stato, win;
  logic       ev;

  logic       b_setup, b_mv, b_rd;
  logic [1:0] b_m, b_p;
  logic [1:0] b_pp, b_ps, b_pa, b_rn;
  logic [7:0] b_hist;
  logic [1:0] b_stato, b_win;
  logic       b_ev;

  partita_scoreboard #(.CW(4), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .INIZIO_SETUP(setup), .MANCHE_VALID(mv),
    .MANCHE(m), .PARTITA(p), .PUNTI_PRIMO(pp), .PUNTI_SECONDO(ps),
    .PAREGGI(pa), .ROUNDS(rn), .HISTORY(hist), .STATO(stato),
    .EVT_VALID(ev), .EVT_WINNER(win), .EVT_READY(rd)
  );

  partita_scoreboard #(.CW(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .INIZIO_SETUP(b_setup), .MANCHE_VALID(b_mv),
    .MANCHE(b_m), .PARTITA(b_p), .PUNTI_PRIMO(b_pp), .PUNTI_SECONDO(b_ps),
    .PAREGGI(b_pa), .ROUNDS(b_rn), .HISTORY(b_hist), .STATO(b_stato),
    .EVT_VALID(b_ev), .EVT_WINNER(b_win), .EVT_READY(b_rd)
  );

  typedef struct {
    logic [3:0] pp, ps, pa, rn;
    logic [7:0] hist;
    logic [1:0] st;
    logic       ev;
    logic [1:0] win;
  } snap_t;

  snap_t expq[$];
  snap_t mdl;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input snap_t e, input string tag);
    check({tag, ".pp"},   32'(pp),    32'(e.pp));
    check({tag, ".ps"},   32'(ps),    32'(e.ps));
    check({tag, ".pa"},   32'(pa),    32'(e.pa));
    check({tag, ".rn"},   32'(rn),    32'(e.rn));
    check({tag, ".hist"}, 32'(hist),  32'(e.hist));
    check({tag, ".st"},   32'(stato), 32'(e.st));
    check({tag, ".ev"},   32'(ev),    32'(e.ev));
    check({tag, ".win"},  32'(win),   32'(e.win));
  endtask

  function automatic logic [3:0] sat4(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  task automatic mdl_step(input logic s, input logic v, input logic [1:0] mm,
                          input logic [1:0] pr, input logic r);
    if (s) begin
      mdl.st = 2'b01; mdl.pp = 0; mdl.ps = 0; mdl.pa = 0; mdl.rn = 0;
      mdl.hist = 0; mdl.ev = 0;
    end else begin
      if (mdl.ev && r) mdl.ev = 0;
      if (mdl.st == 2'b01 && v) begin
        if (mm == 2'b01) mdl.pp = sat4(mdl.pp);
        if (mm == 2'b10) mdl.ps = sat4(mdl.ps);
        if (mm == 2'b11) mdl.pa = sat4(mdl.pa);
        if (mm != 2'b00) begin
          mdl.rn = sat4(mdl.rn);
          mdl.hist = {mdl.hist[5:0], mm};
        end
        if (pr != 2'b00) begin
          mdl.st = 2'b10; mdl.ev = 1; mdl.win = pr;
        end
      end
    end
  endtask

  task automatic cycle(input logic s, input logic v, input logic [1:0] mm,
                       input logic [1:0] pr, input logic r, input string tag);
    setup = s; mv = v; m = mm; p = pr; rd = r;
    mdl_step(s, v, mm, pr, r);
    expq.push_back(mdl);
    @(posedge clk);
    #1;
    check_a(expq.pop_front(), tag);
    setup = 0; mv = 0; m = 0; p = 0; rd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_pp, exp_st;
    logic       exp_ev;
    setup = 0; mv = 0; rd = 0; m = 0; p = 0;
    b_setup = 0; b_mv = 0; b_rd = 0; b_m = 0; b_p = 0;
    mdl = '{default: '0};

    #12;
    expq.push_back(mdl);
    check_a(expq.pop_front(), "reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    cycle(0, 1, 2'b01, 2'b00, 0, "idle_ignore");
    cycle(1, 0, 2'b00, 2'b00, 0, "setup");
    cycle(0, 1, 2'b01, 2'b00, 0, "r_primo");
    cycle(0, 1, 2'b10, 2'b00, 0, "r_secondo");
    cycle(0, 1, 2'b11, 2'b00, 0, "r_pari");
    cycle(0, 1, 2'b00, 2'b00, 0, "r_invalid");
    cycle(0, 1, 2'b01, 2'b01, 0, "end_primo");
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'b00, 2'b00, 0, "hold");
    cycle(0, 0, 2'b00, 2'b00, 1, "accept");
    cycle(0, 0, 2'b00, 2'b00, 1, "ready_no_evt");
    cycle(0, 1, 2'b10, 2'b00, 0, "fine_ignore");
    cycle(0, 1, 2'b10, 2'b01, 0, "fine_ignore_p");
    cycle(1, 1, 2'b10, 2'b00, 0, "setup_prio");
    cycle(0, 1, 2'b10, 2'b10, 0, "end_secondo");

    b_setup = 1;
    @(posedge clk);
    #1 b_setup = 0;
    check("b_setup.st", 32'(b_stato), 32'd1);
    check("b_setup.pp", 32'(b_pp), 32'd0);
    for (int n = 1; n <= 5; n++) begin
      b_mv = 1; b_m = 2'b01;
      @(posedge clk);
      #1 b_mv = 0; b_m = 0;
      exp_pp = (n < 3) ? 2'(n) : 2'd3;
`ifdef SCOREBOARD_AUTOFINE_EN
      exp_st = (n >= 3) ? 2'b10 : 2'b01;
      exp_ev = (n >= 3);
`else
      exp_st = 2'b01;
      exp_ev = 1'b0;
`endif
      check("b_sat.pp", 32'(b_pp), 32'(exp_pp));
      check("b_sat.rn", 32'(b_rn), 32'(exp_pp));
      check("b_sat.st", 32'(b_stato), 32'(exp_st));
      check("b_sat.ev", 32'(b_ev), 32'(exp_ev));
      if (exp_ev) check("b_sat.win", 32'(b_win), 32'd1);
    end

    #2 rst_n = 1'b0;
    #1;
    mdl = '{default: '0};
    expq.push_back(mdl);
    check_a(expq.pop_front(), "async_rst");
    check("b_async.pp", 32'(b_pp), 32'd0);
    check("b_async.st", 32'(b_stato), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/partita_scoreboard.md
Name: partita_scoreboard

Overview:
- Downstream consumer of the game datapath. Samples each round result (MANCHE) and match status (PARTITA) the datapath produces.
- Keeps per-player round tallies, a draw count, a round count and a short history of round outcomes.
- When the match ends, latches the winner and offers it to the display/host logic through a valid/ready event handshake.

Parameters:
CW, 4, width of every tally/round counter (saturating)
DEPTH, 4, number of round results held in HISTORY (2 bits each)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
INIZIO_SETUP  in  1  new-match request; same signal that drives the datapath setup
MANCHE_VALID  in  1  one-cycle strobe: MANCHE/PARTITA carry a fresh round result
MANCHE  in  2  round result: 00 invalid move, 01 PRIMO wins, 10 SECONDO wins, 11 draw
PARTITA  in  2  match status: 00 ongoing, 01 PRIMO wins, 10 SECONDO wins, 11 match draw
PUNTI_PRIMO  out  CW  rounds won by PRIMO
PUNTI_SECONDO  out  CW  rounds won by SECONDO
PAREGGI  out  CW  drawn rounds
ROUNDS  out  CW  valid rounds played (MANCHE != 00)
HISTORY  out  2*DEPTH  last DEPTH MANCHE codes; bits [1:0] hold the newest
STATO  out  2  FSM state: 00 IDLE, 01 GIOCO, 10 FINE
EVT_VALID  out  1  match-end event pending
EVT_WINNER  out  2  latched PARTITA code of the ended match
EVT_READY  in  1  consumer accepts the event

Behaviour:
- Reset (rst_n low, asynchronous) clears every counter, HISTORY, EVT_VALID, EVT_WINNER and STATO to 0 (IDLE). All other logic is synchronous to the rising edge of clk.
- IDLE: ignores MANCHE_VALID. INIZIO_SETUP=1 moves to GIOCO and clears counters/HISTORY.
- GIOCO: on MANCHE_VALID=1 (single-cycle latency, outputs update on the same edge):
  - MANCHE=01/10/11 increments PUNTI_PRIMO, PUNTI_SECONDO or PAREGGI respectively, and increments ROUNDS.
  - MANCHE=00 changes no counter and is not shifted into HISTORY.
  - Valid codes shift HISTORY left by 2 and insert the new code at [1:0]; the oldest entry is dropped.
  - If PARTITA!=00 in the same sample, the round is counted first. The FSM then moves to FINE, EVT_WINNER<=PARTITA and EVT_VALID<=1.
- FINE: MANCHE_VALID is ignored; counters and HISTORY are frozen.
- INIZIO_SETUP=1 from any state returns to GIOCO with counters, HISTORY and EVT_VALID cleared. INIZIO_SETUP has priority over a MANCHE_VALID in the same cycle.
- Event handshake:
  - EVT_VALID stays high, with EVT_WINNER stable, until a cycle with EVT_VALID&&EVT_READY; EVT_VALID is cleared on the next edge.
  - EVT_READY while EVT_VALID=0 has no effect.
- Counters saturate at 2^CW-1 and never wrap.
- MANCHE_VALID with PARTITA=00 while in FINE is ignored; no new event is raised.

Optional Feature:
- Macro SCOREBOARD_AUTOFINE_EN.
- Defined:
  - In GIOCO, when PUNTI_PRIMO or PUNTI_SECONDO reaches the saturation value, the block forces FINE and raises an event with EVT_WINNER=01 or 10 even if PARTITA=00.
  - If both counters saturate on the same edge, EVT_WINNER=11.
- Not defined: saturation only clamps the counters; FINE is entered solely on PARTITA!=00.

Decomposition:
- Package partita_pkg holds:
  - typedef enum for the FSM states (IDLE, GIOCO, FINE)
  - localparams for the MANCHE codes (M_INVALID, M_PRIMO, M_SECONDO, M_PARI) and the PARTITA codes
- One sub-module, sat_counter (parameter W; inputs clr, inc; output q; saturating). It is instantiated four times for the three tallies and ROUNDS.

Test Plan:
- Reset, then INIZIO_SETUP=1 for one cycle -> STATO=01, all counters 0, HISTORY=0.
- MANCHE_VALID with MANCHE 01,10,11,00 in sequence (PARTITA=00) -> PUNTI_PRIMO=1, PUNTI_SECONDO=1, PAREGGI=1, ROUNDS=3, HISTORY[5:0]=011011.
- MANCHE=01 with PARTITA=01 -> PUNTI_PRIMO increments; STATO=10, EVT_VALID=1, EVT_WINNER=01.
  - Hold EVT_READY=0 for 3 cycles -> event stays high and stable.
  - Raise EVT_READY -> EVT_VALID=0 one cycle later.
- In FINE, pulse MANCHE_VALID with MANCHE=10 -> no counter or HISTORY change.
  - INIZIO_SETUP together with MANCHE_VALID -> setup wins, counters 0, STATO=01.
- Assert rst_n=0 mid-cycle while EVT_VALID=1 -> all outputs 0 immediately, without waiting for a clock edge.
- CW=2: five PRIMO wins -> PUNTI_PRIMO holds 3. With SCOREBOARD_AUTOFINE_EN, the third win -> STATO=10, EVT_WINNER=01.
